// File: rtl/sevenseg_scan.sv
// rtl/sevenseg_scan.sv - time-multiplexed common-anode seven-segment scanner with dark-cycle anti-ghosting
// Optional per-digit blinking is built only when SEVENSEG_BLINK_EN is defined.
module sevenseg_scan #(
    parameter int DIGITS       = 4,
    parameter int SCAN_DIV     = 50000,
    parameter int HEX          = 0,
    parameter int BLINK_FRAMES = 25
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   data,
    input  logic [DIGITS-1:0]     dp,
    input  logic                  blank_lz,
    input  logic [DIGITS-1:0]     blink_mask,
    output logic [6:0]            seg,
    output logic                  dp_n,
    output logic [DIGITS-1:0]     an
);
    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    logic [PW-1:0]         presc;
    logic [IW-1:0]         idx;
    logic [IW-1:0]         idx_next;
    logic [4*DIGITS-1:0]   shadow_code;
    logic [DIGITS-1:0]     shadow_dp;
    logic                  arm;
    logic                  tick;
    logic                  lz_blank;
    logic                  blink_off;
    logic [3:0]            code_sel;

    assign tick     = (presc == PW'(SCAN_DIV - 1));
    assign idx_next = (idx == IW'(DIGITS - 1)) ? '0 : idx + 1'b1;
    assign code_sel = shadow_code[int'(idx_next)*4 +: 4];

    function automatic logic [6:0] glyph(input logic [3:0] c);
        case (c)
            4'h0: glyph = 7'b100_0000;
            4'h1: glyph = 7'b111_1001;
            4'h2: glyph = 7'b010_0100;
            4'h3: glyph = 7'b011_0000;
            4'h4: glyph = 7'b001_1001;
            4'h5: glyph = 7'b001_0010;
            4'h6: glyph = 7'b000_0010;
            4'h7: glyph = 7'b111_1000;
            4'h8: glyph = 7'b000_0000;
            4'h9: glyph = 7'b001_0000;
            4'hA: glyph = (HEX != 0) ? 7'b000_1000 : 7'b111_1111;
            4'hB: glyph = (HEX != 0) ? 7'b000_0011 : 7'b111_1111;
            4'hC: glyph = (HEX != 0) ? 7'b100_0110 : 7'b111_1111;
            4'hD: glyph = (HEX != 0) ? 7'b010_0001 : 7'b111_1111;
            4'hE: glyph = (HEX != 0) ? 7'b000_0110 : 7'b111_1111;
            default: glyph = (HEX != 0) ? 7'b000_1110 : 7'b111_1111;
        endcase
    endfunction

    // The incoming digit is dark if it and every digit to its left hold zero.
    always_comb begin
        lz_blank = blank_lz && (idx_next != '0);
        for (int i = 0; i < DIGITS; i++) begin
            if (i >= int'(idx_next) && shadow_code[4*i +: 4] != 4'd0)
                lz_blank = 1'b0;
        end
    end

`ifdef SEVENSEG_BLINK_EN
    localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic [FW-1:0] frame_cnt;
    logic          phase;
    logic          frame_wrap;
    logic          phase_next;

    assign frame_wrap = tick && (idx == IW'(DIGITS - 1));
    assign phase_next = (frame_wrap && frame_cnt == FW'(BLINK_FRAMES - 1)) ? ~phase : phase;
    assign blink_off  = phase_next & blink_mask[idx_next];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt <= '0;
            phase     <= 1'b0;
        end else if (frame_wrap) begin
            phase <= phase_next;
            if (frame_cnt == FW'(BLINK_FRAMES - 1))
                frame_cnt <= '0;
            else
                frame_cnt <= frame_cnt + 1'b1;
        end
    end
`else
    // blink_mask has no effect in this build.
    assign blink_off = 1'b0 & (|blink_mask);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc       <= '0;
            idx         <= IW'(DIGITS - 1);
            shadow_code <= '0;
            shadow_dp   <= '0;
            seg         <= 7'b111_1111;
            dp_n        <= 1'b1;
            an          <= '1;
            arm         <= 1'b0;
        end else begin
            presc <= tick ? '0 : presc + 1'b1;
            if (load) begin
                shadow_code <= data;
                shadow_dp   <= dp;
            end
            // Pattern is latched with the dark cycle so mid-slot loads never tear.
            if (tick) begin
                idx  <= idx_next;
                an   <= '1;
                arm  <= 1'b1;
                seg  <= (lz_blank || blink_off) ? 7'b111_1111 : glyph(code_sel);
                dp_n <= blink_off | ~shadow_dp[idx_next];
            end else if (arm) begin
                an  <= ~(DIGITS'(1) << idx);
                arm <= 1'b0;
            end
        end
    end
endmodule
